// File: rtl/ifdef_cond_stack.sv
// Conditional-compilation sequencer: tags preprocessor tokens live/dead using a macro table
// and an ifdef nesting stack, with a one-deep registered output stage.
module ifdef_cond_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SYM_W = 4,
    localparam int unsigned DW   = $clog2(DEPTH + 1),
    localparam int unsigned NSYM = 2 ** SYM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [SYM_W-1:0] in_sym,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_op,
    output logic [SYM_W-1:0] out_sym,
    output logic             out_active,
    output logic [DW-1:0]    depth,
    output logic [NSYM-1:0]  def_mask,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam logic [2:0] OpLine   = 3'd0;
    localparam logic [2:0] OpDefine = 3'd1;
    localparam logic [2:0] OpUndef  = 3'd2;
    localparam logic [2:0] OpIfdef  = 3'd3;
    localparam logic [2:0] OpIfndef = 3'd4;
    localparam logic [2:0] OpElsif  = 3'd5;
    localparam logic [2:0] OpElse   = 3'd6;
    localparam logic [2:0] OpEndif  = 3'd7;

    localparam logic [1:0] ErrNone     = 2'd0;
    localparam logic [1:0] ErrOverflow = 2'd1;
    localparam logic [1:0] ErrOrphan   = 2'd2;
    localparam logic [1:0] ErrUnterm   = 2'd3;

    logic [DEPTH-1:0] stk_par_q, stk_taken_q, stk_cur_q, stk_else_q;
    logic [DEPTH-1:0] stk_par_d, stk_taken_d, stk_cur_d, stk_else_d;
    logic [DW-1:0]    depth_d, top;
    logic [NSYM-1:0]  def_mask_d;
    logic             live, top_par, top_taken, top_else, hit, branch, act, drop, accept;
    logic [1:0]       code;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        top       = depth - DW'(1);
        live      = 1'b1;
        top_par   = 1'b0;
        top_taken = 1'b0;
        top_else  = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (depth != '0 && DW'(i) == top) begin
                live      = stk_cur_q[i];
                top_par   = stk_par_q[i];
                top_taken = stk_taken_q[i];
                top_else  = stk_else_q[i];
            end
        end
        hit         = def_mask[in_sym];
        stk_par_d   = stk_par_q;
        stk_taken_d = stk_taken_q;
        stk_cur_d   = stk_cur_q;
        stk_else_d  = stk_else_q;
        depth_d     = depth;
        def_mask_d  = def_mask;
        drop        = 1'b0;
        code        = ErrNone;
        branch      = 1'b0;
        act         = live;

        case (in_op)
            OpDefine: if (live) def_mask_d[in_sym] = 1'b1;
            OpUndef:  if (live) def_mask_d[in_sym] = 1'b0;
            OpIfdef, OpIfndef: begin
                if (depth == DW'(DEPTH)) begin
                    drop = 1'b1;
                    code = ErrOverflow;
                end else begin
                    branch = live && (hit ^ (in_op == OpIfndef));
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        if (DW'(i) == depth) begin
                            stk_par_d[i]   = live;
                            stk_cur_d[i]   = branch;
                            stk_taken_d[i] = branch;
                            stk_else_d[i]  = 1'b0;
                        end
                    end
                    depth_d = depth + DW'(1);
                    act     = branch;
                end
            end
            OpElsif, OpElse: begin
                if (depth == '0 || top_else) begin
                    drop = 1'b1;
                    code = ErrOrphan;
                end else begin
                    branch = top_par && !top_taken && (in_op == OpElse || hit);
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        if (DW'(i) == top) begin
                            stk_cur_d[i]   = branch;
                            stk_taken_d[i] = top_taken || branch || (in_op == OpElse);
                            stk_else_d[i]  = (in_op == OpElse);
                        end
                    end
                    act = branch;
                end
            end
            OpEndif: begin
                if (depth == '0) begin
                    drop = 1'b1;
                    code = ErrOrphan;
                end else begin
                    depth_d = top;
                    act     = top_par;
                end
            end
            default: ;
        endcase

        // End of stream closes every open block; the macro table survives.
        if (in_last) begin
            if (depth_d != '0 && code == ErrNone) code = ErrUnterm;
            depth_d     = '0;
            stk_par_d   = '0;
            stk_taken_d = '0;
            stk_cur_d   = '0;
            stk_else_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_op      <= 3'd0;
            out_sym     <= '0;
            out_active  <= 1'b0;
            depth       <= '0;
            def_mask    <= '0;
            err         <= 1'b0;
            err_code    <= ErrNone;
            stk_par_q   <= '0;
            stk_taken_q <= '0;
            stk_cur_q   <= '0;
            stk_else_q  <= '0;
        end else if (accept) begin
            out_valid  <= !drop;
            out_op     <= in_op;
            out_sym    <= in_sym;
            out_active <= act;
            if (!drop) begin
                def_mask    <= def_mask_d;
                stk_par_q   <= stk_par_d;
                stk_taken_q <= stk_taken_d;
                stk_cur_q   <= stk_cur_d;
                stk_else_q  <= stk_else_d;
            end
            depth <= drop ? (in_last ? '0 : depth) : depth_d;
            if (in_last) begin
                stk_par_q   <= '0;
                stk_taken_q <= '0;
                stk_cur_q   <= '0;
                stk_else_q  <= '0;
            end
            if (code != ErrNone) begin
                err <= 1'b1;
                if (!err) err_code <= code;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ifdef_cond_stack.sv
// Randomised scoreboard bench for ifdef_cond_stack against a queue-based preprocessor model.
module tb_ifdef_cond_stack;
    localparam int DEPTH = 8;
    localparam int SYM_W = 4;
    localparam int NSYM  = 16;
    localparam int DW    = 4;

    localparam logic [2:0] LINE = 3'd0, DEFINE = 3'd1, UNDEF = 3'd2, IFDEF = 3'd3;
    localparam logic [2:0] IFNDEF = 3'd4, ELSIF = 3'd5, ELSE = 3'd6, ENDIF = 3'd7;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = 3'd0;
    logic [SYM_W-1:0] in_sym = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [2:0]       out_op;
    logic [SYM_W-1:0] out_sym;
    logic             out_active;
    logic [DW-1:0]    depth;
    logic [NSYM-1:0]  def_mask;
    logic             err;
    logic [1:0]       err_code;

    ifdef_cond_stack #(.DEPTH(DEPTH), .SYM_W(SYM_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_sym(in_sym), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_sym(out_sym), .out_active(out_active), .depth(depth),
        .def_mask(def_mask), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [2:0]       op;
        logic [SYM_W-1:0] sym;
        logic             act;
    } exp_t;
    exp_t sbq[$];

    // Reference model: stack of open blocks, macro set, first-error latch.
    typedef struct {
        bit par;
        bit taken;
        bit cur;
        bit els;
    } ent_t;
    ent_t            stk[$];
    bit [NSYM-1:0]   m_def;
    bit              m_err;
    int              m_code;
    bit              bp_rand = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        stk.delete();
        m_def  = '0;
        m_err  = 1'b0;
        m_code = 0;
    endfunction

    function automatic void model_step(input logic [2:0] op, input logic [3:0] sym,
                                       input logic last, output bit fwd, output bit act);
        bit   a;
        int   code;
        ent_t e;
        a    = (stk.size() == 0) ? 1'b1 : stk[$].cur;
        act  = a;
        fwd  = 1'b1;
        code = 0;
        if (op == DEFINE && a) m_def[sym] = 1'b1;
        else if (op == UNDEF && a) m_def[sym] = 1'b0;
        else if (op == IFDEF || op == IFNDEF) begin
            if (stk.size() == DEPTH) begin
                fwd = 0; code = 1;
            end else begin
                e.par   = a;
                e.cur   = a && ((op == IFDEF) ? m_def[sym] : !m_def[sym]);
                e.taken = e.cur;
                e.els   = 1'b0;
                stk.push_back(e);
                act = e.cur;
            end
        end else if (op == ELSIF || op == ELSE) begin
            if (stk.size() == 0 || stk[$].els) begin
                fwd = 0; code = 2;
            end else begin
                e = stk.pop_back();
                e.cur = e.par && !e.taken && (op == ELSE || m_def[sym]);
                e.taken = e.taken || e.cur || (op == ELSE);
                e.els = (op == ELSE);
                stk.push_back(e);
                act = e.cur;
            end
        end else if (op == ENDIF) begin
            if (stk.size() == 0) begin
                fwd = 0; code = 2;
            end else begin
                e = stk.pop_back();
                act = e.par;
            end
        end
        if (last) begin
            if (stk.size() != 0 && code == 0) code = 3;
            stk.delete();
        end
        if (code != 0) begin
            if (!m_err) m_code = code;
            m_err = 1'b1;
        end
    endfunction

    task automatic send(input logic [2:0] op, input logic [3:0] sym, input logic last);
        bit fwd, act;
        int n = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_sym   = sym;
        in_last  = last;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout: in_ready stuck low, expected high within 50 cycles");
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        model_step(op, sym, last, fwd, act);
        if (fwd) sbq.push_back({op, sym, act});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_depth"}, int'(depth), stk.size());
        chk({tag, "_def_mask"}, int'(def_mask), int'(m_def));
        chk({tag, "_err"}, int'(err), int'(m_err));
        chk({tag, "_err_code"}, int'(err_code), m_code);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL drain_timeout: %0d outputs outstanding, expected 0", sbq.size());
                sbq.delete();
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        model_reset();
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_depth", int'(depth), 0);
        chk("rst_def_mask", int'(def_mask), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_code", int'(err_code), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every transfer and checks hold-while-stalled.
    bit   held = 1'b0;
    exp_t held_val;
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            chk("in_ready_rule", int'(in_ready), int'(!out_valid || out_ready));
            if (held) chk("stall_stable", int'({out_valid, out_op, out_sym, out_active}),
                          int'({1'b1, held_val}));
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out", int'({out_op, out_sym, out_active}), -1);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("out_token", int'({out_op, out_sym, out_active}), int'(e));
                end
            end
            held     = out_valid && !out_ready;
            held_val = {out_op, out_sym, out_active};
        end
    end

    always @(posedge clk) begin
        #1;
        if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        model_reset();
        do_reset();

        // Elsif chain
        send(DEFINE, 1, 0); send(IFDEF, 0, 0); send(LINE, 0, 0); send(ELSIF, 1, 0);
        send(LINE, 0, 0); send(ELSE, 0, 0); send(LINE, 0, 0); send(ENDIF, 0, 0);
        drain();
        check_state("elsif");
        chk("elsif_def_mask_const", int'(def_mask), 16'h0002);

        // Scoped define inside the taken else branch
        send(IFDEF, 2, 0); send(ELSIF, 3, 0); send(ELSE, 0, 0); send(DEFINE, 5, 0);
        send(LINE, 0, 0); send(ENDIF, 0, 0);
        drain();
        check_state("scoped");
        chk("scoped_def5", int'(def_mask[5]), 1);

        // Define in a dead region has no effect
        do_reset();
        send(IFDEF, 0, 0); send(DEFINE, 4, 0); send(ENDIF, 0, 0); send(IFDEF, 4, 0);
        send(LINE, 0, 0); send(ENDIF, 0, 0);
        drain();
        check_state("dead");
        chk("dead_def4", int'(def_mask[4]), 0);

        // Overflow, then a later orphan must not replace the first code
        do_reset();
        for (int i = 0; i < 9; i++) send(IFDEF, 0, 0);
        drain();
        check_state("ovf");
        chk("ovf_depth_const", int'(depth), 8);
        chk("ovf_code_const", int'(err_code), 1);
        for (int i = 0; i < 8; i++) send(ENDIF, 0, 0);
        send(ELSE, 0, 0);
        drain();
        check_state("ovf_orphan");
        chk("ovf_code_kept", int'(err_code), 1);

        // Orphan endif, then unterminated stream
        do_reset();
        send(ENDIF, 0, 0);
        drain();
        check_state("orphan");
        chk("orphan_code_const", int'(err_code), 2);
        do_reset();
        send(IFDEF, 0, 1);
        drain();
        check_state("unterm");
        chk("unterm_code_const", int'(err_code), 3);
        chk("unterm_depth_const", int'(depth), 0);

        // Backpressure: three stalled cycles mid-stream
        do_reset();
        send(DEFINE, 7, 0); send(IFDEF, 7, 0);
        out_ready = 1'b0;
        fork
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", int'(in_ready), 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join_none
        send(LINE, 0, 0); send(IFNDEF, 7, 0); send(LINE, 0, 0); send(ENDIF, 0, 0);
        send(ENDIF, 0, 0);
        drain();
        check_state("bp");

        // Random streams with random backpressure and one mid-stream reset
        do_reset();
        bp_rand = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [2:0] op;
            r = $urandom_range(0, 99);
            if (r < 15) op = LINE;
            else if (r < 27) op = DEFINE;
            else if (r < 33) op = UNDEF;
            else if (r < 50) op = IFDEF;
            else if (r < 58) op = IFNDEF;
            else if (r < 66) op = ELSIF;
            else if (r < 75) op = ELSE;
            else op = ENDIF;
            send(op, 4'($urandom_range(0, NSYM - 1)), ($urandom_range(0, 39) == 0));
            if (n % 16 == 15) check_state("rand");
            if (n == 1500) do_reset();
        end
        bp_rand = 1'b0;
        out_ready = 1'b1;
        drain();
        check_state("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
